// File: rtl/spi_pixel_writer_if.sv
// SPI pin bundle and framebuffer write port for the pixel writer.
// The host side (master) drives the SPI pins; the writer (slave) drives the write port.
interface spi_pixel_writer_if;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       strobe;
    logic       frame_done;
    logic       hdr_err;
    logic       busy;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  x, y, r, g, b, strobe, frame_done, hdr_err, busy
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output x, y, r, g, b, strobe, frame_done, hdr_err, busy
    );
endinterface

// File: rtl/spi_pixel_writer.sv
// SPI mode-0 slave turning a header (x, y) plus streamed RGB triples into
// single-cycle framebuffer write strobes with raster-order auto-increment.
//
// state   | meaning
// IDLE    | cs high, or waiting for a fresh cs low after reset
// GET_X   | expecting start column byte
// GET_Y   | expecting start row byte, range-checks header
// GET_R   | expecting red byte
// GET_G   | expecting green byte
// GET_B   | expecting blue byte, issues the write
// DISCARD | bad header, swallow bytes until cs goes high
module spi_pixel_writer #(
    parameter int X_RES = 32,
    parameter int Y_RES = 16
) (
    input logic              clk_48mhz,
    input logic              reset,
    spi_pixel_writer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, GET_X, GET_Y, GET_R, GET_G, GET_B, DISCARD} state_t;

    state_t     state, state_nxt;
    logic [1:0] sck_ff, cs_ff, mosi_ff;
    logic       sck_prev;
    logic       sck_rise, cs_sync, mosi_sync;
    logic [1:0] primed;
    logic       armed;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_valid;
    logic [7:0] cur_x, cur_y, pix_r, pix_g;
    logic       latch_x, latch_y, latch_r, latch_g, wr_issue, hdr_bad;
    logic       x_oob, y_oob, x_last, y_last;
    logic [7:0] x_q, y_q, r_q, g_q, b_q;
    logic       strobe_q, frame_done_q, hdr_err_q;

    // cs synchroniser resets to "deselected" so busy reads 0 out of reset
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sck_ff   <= 2'b00;
            cs_ff    <= 2'b11;
            mosi_ff  <= 2'b00;
            sck_prev <= 1'b0;
        end else begin
            sck_ff   <= {sck_ff[0], bus.spi_sck};
            cs_ff    <= {cs_ff[0], bus.spi_cs_n};
            mosi_ff  <= {mosi_ff[0], bus.spi_mosi};
            sck_prev <= sck_ff[1];
        end
    end

    assign sck_rise  = sck_ff[1] & ~sck_prev;
    assign cs_sync   = cs_ff[1];
    assign mosi_sync = mosi_ff[1];

    // armed only after a genuine cs-high sample, ignoring the synchroniser's reset value
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && cs_sync)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_sync || !armed || state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shreg   <= {shreg[6:0], mosi_sync};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_valid <= 1'b1;
            end
        end
    end

    assign x_oob  = {1'b0, cur_x} >= 9'(X_RES);
    assign y_oob  = {1'b0, shreg} >= 9'(Y_RES);
    assign x_last = cur_x == 8'(X_RES - 1);
    assign y_last = cur_y == 8'(Y_RES - 1);

    always_ff @(posedge clk_48mhz) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_x   = 1'b0;
        latch_y   = 1'b0;
        latch_r   = 1'b0;
        latch_g   = 1'b0;
        wr_issue  = 1'b0;
        hdr_bad   = 1'b0;
        if (cs_sync) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (armed) state_nxt = GET_X;
                GET_X:   if (byte_valid) begin
                             latch_x   = 1'b1;
                             state_nxt = GET_Y;
                         end
                GET_Y:   if (byte_valid) begin
                             latch_y = 1'b1;
                             if (x_oob || y_oob) begin
                                 hdr_bad   = 1'b1;
                                 state_nxt = DISCARD;
                             end else begin
                                 state_nxt = GET_R;
                             end
                         end
                GET_R:   if (byte_valid) begin
                             latch_r   = 1'b1;
                             state_nxt = GET_G;
                         end
                GET_G:   if (byte_valid) begin
                             latch_g   = 1'b1;
                             state_nxt = GET_B;
                         end
                GET_B:   if (byte_valid) begin
                             wr_issue  = 1'b1;
                             state_nxt = GET_R;
                         end
                DISCARD: state_nxt = DISCARD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            cur_x        <= 8'd0;
            cur_y        <= 8'd0;
            pix_r        <= 8'd0;
            pix_g        <= 8'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            b_q          <= 8'd0;
            strobe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            strobe_q     <= wr_issue;
            frame_done_q <= wr_issue && x_last && y_last;
            hdr_err_q    <= hdr_bad;
            if (latch_x) cur_x <= shreg;
            if (latch_y) cur_y <= shreg;
            if (latch_r) pix_r <= shreg;
            if (latch_g) pix_g <= shreg;
            if (wr_issue) begin
                x_q <= cur_x;
                y_q <= cur_y;
                r_q <= pix_r;
                g_q <= pix_g;
                b_q <= shreg;
                if (x_last) begin
                    cur_x <= 8'd0;
                    cur_y <= y_last ? 8'd0 : cur_y + 8'd1;
                end else begin
                    cur_x <= cur_x + 8'd1;
                end
            end
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.r          = r_q;
    assign bus.g          = g_q;
    assign bus.b          = b_q;
    assign bus.strobe     = strobe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.hdr_err    = hdr_err_q;
    assign bus.busy       = ~cs_sync;

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Directed bench for spi_pixel_writer: bit-bangs SPI transactions and checks
// the captured write strobes against hand-computed pixels.
module tb_spi_pixel_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;

    spi_pixel_writer_if bus();

    spi_pixel_writer #(.X_RES(32), .Y_RES(16)) dut (
        .clk_48mhz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    // captured writes as {frame_done, x, y, r, g, b}
    logic [40:0] got_q[$];
    int          hdr_cnt = 0;
    int          dbl_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (bus.strobe)
            got_q.push_back({bus.frame_done, bus.x, bus.y, bus.r, bus.g, bus.b});
        if (bus.strobe && prev_strobe)
            dbl_cnt = dbl_cnt + 1;
        prev_strobe = bus.strobe;
        if (bus.hdr_err)
            hdr_cnt = hdr_cnt + 1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic v);
        bus.spi_mosi = v;
        clk_wait(8);
        bus.spi_sck = 1'b1;
        clk_wait(8);
        bus.spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            spi_bit(v[i]);
    endtask

    task automatic cs_begin();
        bus.spi_cs_n = 1'b0;
        clk_wait(8);
    endtask

    task automatic cs_end();
        clk_wait(8);
        bus.spi_cs_n = 1'b1;
        clk_wait(16);
    endtask

    task automatic send_tx();
        cs_begin();
        foreach (tx_q[i])
            spi_byte(tx_q[i]);
        cs_end();
    endtask

    function automatic logic [40:0] outs_now();
        return {bus.frame_done, bus.x, bus.y, bus.r, bus.g, bus.b};
    endfunction

    task automatic test_reset();
        logic [42:0] got;
        reset = 1'b1;
        clk_wait(4);
        reset = 1'b0;
        clk_wait(1);
        got = {outs_now(), bus.strobe, bus.hdr_err};
        total++;
        if (got !== 43'd0) $display("FAIL reset_outputs: got %h expected 0", got);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
        else passed++;
        clk_wait(8);
    endtask

    task automatic test_single_pixel();
        int base = got_q.size();
        int hbase = hdr_cnt;
        cs_begin();
        total++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy_high: got %b expected 1", bus.busy);
        else passed++;
        spi_byte(8'h03); spi_byte(8'h05); spi_byte(8'hFF); spi_byte(8'h80); spi_byte(8'h01);
        cs_end();
        total++;
        if (got_q.size() - base !== 1) $display("FAIL single_count: got %0d expected 1", got_q.size() - base);
        else passed++;
        if (got_q.size() > base) begin
            total++;
            if (got_q[base] !== {1'b0, 8'd3, 8'd5, 8'hFF, 8'h80, 8'h01})
                $display("FAIL single_pixel: got %h expected %h", got_q[base], {1'b0, 8'd3, 8'd5, 8'hFF, 8'h80, 8'h01});
            else passed++;
        end
        total++;
        if (hdr_cnt - hbase !== 0) $display("FAIL single_hdr_err: got %0d expected 0", hdr_cnt - hbase);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL single_busy_low: got %b expected 0", bus.busy);
        else passed++;
        clk_wait(20);
        total++;
        if (outs_now() !== {1'b0, 8'd3, 8'd5, 8'hFF, 8'h80, 8'h01})
            $display("FAIL single_hold: got %h expected %h", outs_now(), {1'b0, 8'd3, 8'd5, 8'hFF, 8'h80, 8'h01});
        else passed++;
    endtask

    task automatic test_row_wrap();
        int base = got_q.size();
        tx_q = '{8'h1F, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        send_tx();
        total++;
        if (got_q.size() - base !== 2) $display("FAIL row_count: got %0d expected 2", got_q.size() - base);
        else passed++;
        if (got_q.size() >= base + 2) begin
            total++;
            if (got_q[base] !== {1'b0, 8'd31, 8'd2, 8'h10, 8'h20, 8'h30})
                $display("FAIL row_first: got %h expected %h", got_q[base], {1'b0, 8'd31, 8'd2, 8'h10, 8'h20, 8'h30});
            else passed++;
            total++;
            if (got_q[base+1] !== {1'b0, 8'd0, 8'd3, 8'h40, 8'h50, 8'h60})
                $display("FAIL row_second: got %h expected %h", got_q[base+1], {1'b0, 8'd0, 8'd3, 8'h40, 8'h50, 8'h60});
            else passed++;
        end
    endtask

    task automatic test_frame_wrap();
        int base = got_q.size();
        tx_q = '{8'h1F, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_tx();
        total++;
        if (got_q.size() - base !== 2) $display("FAIL frame_count: got %0d expected 2", got_q.size() - base);
        else passed++;
        if (got_q.size() >= base + 2) begin
            total++;
            if (got_q[base] !== {1'b1, 8'd31, 8'd15, 8'h01, 8'h02, 8'h03})
                $display("FAIL frame_last: got %h expected %h", got_q[base], {1'b1, 8'd31, 8'd15, 8'h01, 8'h02, 8'h03});
            else passed++;
            total++;
            if (got_q[base+1] !== {1'b0, 8'd0, 8'd0, 8'h04, 8'h05, 8'h06})
                $display("FAIL frame_origin: got %h expected %h", got_q[base+1], {1'b0, 8'd0, 8'd0, 8'h04, 8'h05, 8'h06});
            else passed++;
        end
    endtask

    task automatic test_abort();
        int base = got_q.size();
        tx_q = '{8'h00, 8'h00, 8'hAA, 8'hBB};
        send_tx();
        tx_q = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
        send_tx();
        total++;
        if (got_q.size() - base !== 1) $display("FAIL abort_count: got %0d expected 1", got_q.size() - base);
        else passed++;
        if (got_q.size() > base) begin
            total++;
            if (got_q[base] !== {1'b0, 8'd1, 8'd1, 8'h11, 8'h22, 8'h33})
                $display("FAIL abort_pixel: got %h expected %h", got_q[base], {1'b0, 8'd1, 8'd1, 8'h11, 8'h22, 8'h33});
            else passed++;
        end
    endtask

    task automatic test_hdr_err();
        int base = got_q.size();
        int hbase = hdr_cnt;
        tx_q = '{8'h20, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_tx();
        total++;
        if (hdr_cnt - hbase !== 1) $display("FAIL hdr_err_pulses: got %0d expected 1", hdr_cnt - hbase);
        else passed++;
        total++;
        if (got_q.size() - base !== 0) $display("FAIL hdr_err_no_write: got %0d expected 0", got_q.size() - base);
        else passed++;
        tx_q = '{8'h02, 8'h03, 8'h44, 8'h55, 8'h66};
        send_tx();
        total++;
        if (got_q.size() - base !== 1) $display("FAIL hdr_recover_count: got %0d expected 1", got_q.size() - base);
        else passed++;
        if (got_q.size() > base) begin
            total++;
            if (got_q[base] !== {1'b0, 8'd2, 8'd3, 8'h44, 8'h55, 8'h66})
                $display("FAIL hdr_recover_pixel: got %h expected %h", got_q[base], {1'b0, 8'd2, 8'd3, 8'h44, 8'h55, 8'h66});
            else passed++;
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [42:0] got;
        int base = got_q.size();
        cs_begin();
        spi_byte(8'h00); spi_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        reset = 1'b1;
        clk_wait(3);
        reset = 1'b0;
        clk_wait(1);
        got = {outs_now(), bus.strobe, bus.hdr_err};
        total++;
        if (got !== 43'd0) $display("FAIL midreset_outputs: got %h expected 0", got);
        else passed++;
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03);
        spi_byte(8'h04); spi_byte(8'h05); spi_byte(8'h06);
        total++;
        if (got_q.size() - base !== 0) $display("FAIL midreset_ignored: got %0d expected 0", got_q.size() - base);
        else passed++;
        cs_end();
        tx_q = '{8'h04, 8'h06, 8'h07, 8'h08, 8'h09};
        send_tx();
        total++;
        if (got_q.size() - base !== 1) $display("FAIL midreset_fresh_count: got %0d expected 1", got_q.size() - base);
        else passed++;
        if (got_q.size() > base) begin
            total++;
            if (got_q[base] !== {1'b0, 8'd4, 8'd6, 8'h07, 8'h08, 8'h09})
                $display("FAIL midreset_fresh_pixel: got %h expected %h", got_q[base], {1'b0, 8'd4, 8'd6, 8'h07, 8'h08, 8'h09});
            else passed++;
        end
    endtask

    task automatic test_no_double_strobe();
        total++;
        if (dbl_cnt !== 0) $display("FAIL double_strobe: got %0d expected 0", dbl_cnt);
        else passed++;
    endtask

    initial begin
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        test_reset();
        test_single_pixel();
        test_row_wrap();
        test_frame_wrap();
        test_abort();
        test_hdr_err();
        test_reset_mid_byte();
        test_no_double_strobe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_pixel_writer.md
Name: spi_pixel_writer

Overview:
- SPI mode-0 slave that receives pixel data from a host MCU and turns it into single-cycle framebuffer write strobes (x, y, r, g, b, strobe) for the LED matrix driver's write port.
- Sits between the board SPI pins and the matrix driver, entirely in the clk_48mhz domain.
- Supports streamed bursts: one header giving the start coordinate, then any number of RGB triples, with auto-increment in raster order.

Parameters:
X_RES, 32, matrix width in pixels (must be ≤256)
Y_RES, 16, matrix height in pixels (must be ≤256)

Ports:
clk_48mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
spi_sck  input  1  SPI clock from host, asynchronous, mode 0, max 6 MHz
spi_cs_n  input  1  SPI chip select, active-low, asynchronous
spi_mosi  input  1  SPI data in, MSB first
x  output  8  pixel column of current write
y  output  8  pixel row of current write
r  output  8  red value
g  output  8  green value
b  output  8  blue value
strobe  output  1  one-cycle write pulse; x/y/r/g/b valid in that cycle
frame_done  output  1  one-cycle pulse, coincident with strobe for pixel (X_RES-1, Y_RES-1)
hdr_err  output  1  one-cycle pulse when a header is out of range
busy  output  1  high while synchronised cs_n is low

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-high; clock is clk_48mhz.
  - Reset values: all outputs 0; FSM in IDLE; bit counter 0; shift register 0.
  - Reset mid-transaction drops any partial byte or pixel. After reset, data is ignored until cs_n has been seen high, then goes low again.
- Input synchronisation:
  - spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser.
  - An sck rising edge is detected on the synchronised samples (previous 0, current 1).
  - On a rising edge with cs low, the synchronised mosi shifts into an 8-bit register, MSB first, and a 3-bit counter increments.
  - When the counter wraps 7→0, byte_valid pulses for 1 cycle, carrying the completed byte.
- FSM states: IDLE, GET_X, GET_Y, GET_R, GET_G, GET_B, DISCARD.
  - IDLE → GET_X when synchronised cs goes low (bit counter cleared).
  - GET_X: on byte_valid, latch cur_x → GET_Y.
  - GET_Y: on byte_valid, latch cur_y. If cur_x ≥ X_RES or byte ≥ Y_RES, pulse hdr_err and go to DISCARD; else go to GET_R.
  - GET_R → GET_G → GET_B: each latches its byte on byte_valid.
  - GET_B: on byte_valid, go to GET_R and issue a write.
  - DISCARD: consumes bytes without writes until cs goes high.
  - From any state, synchronised cs high → IDLE the same cycle. Partial byte, partial pixel and coordinates are discarded, with no strobe.
- Write issue:
  - strobe asserts the cycle after the byte_valid of the B byte (latency 1 clk).
  - Output x/y/r/g/b update in that same cycle and hold until the next strobe.
  - strobe is never high for 2 consecutive cycles.
- Auto-increment, applied after each write:
  - If cur_x == X_RES-1: cur_x = 0 and cur_y = cur_y+1.
  - If additionally cur_y == Y_RES-1: cur_y = 0 and frame_done pulses with that strobe.
  - Otherwise cur_x = cur_x+1.
  - Writes then continue from (0,0).
- SCK limit: sck ≤ clk/8, so every edge is seen. Higher rates are unsupported; no detection is required.
- busy follows synchronised cs_n inverted (2-cycle latency).
- Simultaneous events: cs deassert in the same cycle as the byte_valid of a B byte takes the abort path; that pixel is not written.

Test Plan:
- Single pixel: cs low, bytes 03 05 FF 80 01, cs high → exactly one strobe with x=3, y=5, r=FF, g=80, b=01; frame_done=0; hdr_err=0.
- Row wrap: header 1F 02, pixels (10,20,30)(40,50,60) → strobes at (31,2) and (0,3) with matching rgb.
- Frame wrap: header 1F 0F, two pixels → strobe (31,15) with frame_done=1, then strobe (0,0) with frame_done=0.
- Abort: header 00 00, bytes AA BB, cs high, then new transaction 01 01 11 22 33 → no strobe for the aborted pixel; single strobe (1,1,11,22,33).
- Header error: header 20 00 (x=32) followed by 6 bytes → hdr_err pulses once; no strobe; next valid transaction writes normally.
- Reset mid-byte: reset asserted after 4 bits of the R byte with cs held low → outputs 0; no strobe until cs toggles high then low and a fresh header is sent.
